// File: rtl/mpls_pkg.sv
// Shared types for the MPLS ingress/egress schedulers: port index type,
// scheduler state encoding and a wrapping index increment.
package mpls_pkg;

    localparam int MAX_PORTS = 32;

    typedef logic [$clog2(MAX_PORTS)-1:0] mpls_port_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    function automatic mpls_port_idx_t wrap_inc(input mpls_port_idx_t idx,
                                                input mpls_port_idx_t last);
        return (idx == last) ? mpls_port_idx_t'(0) : idx + mpls_port_idx_t'(1);
    endfunction

endpackage

// File: rtl/mpls_ingress_wrr_sched_if.sv
// AXI4-Stream bundle shared by the ingress streams and the converged bus.
interface mpls_ingress_wrr_sched_if #(
    parameter int DATA_BYTES = 64,
    parameter int USER_WIDTH = 3,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4
);
    logic                    tvalid;
    logic                    tready;
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/mpls_ingress_rr_pick.sv
// Combinational rotating-priority finder: first set request at or after
// start_i, wrapping past NUM_PORTS-1 back to 0.
module mpls_ingress_rr_pick
    import mpls_pkg::*;
#(
    parameter int NUM_PORTS = 8
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  mpls_port_idx_t       start_i,
    output logic                 found_o,
    output mpls_port_idx_t       idx_o
);

    localparam int IW = $bits(mpls_port_idx_t);
    localparam logic [IW:0] NP_W = NUM_PORTS[IW:0];

    logic [2*NUM_PORTS-1:0] req2_s;
    logic [NUM_PORTS-1:0]   rot_s;
    mpls_port_idx_t         off_s;
    logic [IW:0]            sum_s;

    // Rotate start_i down to bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req2_s = {req_i, req_i};
        rot_s  = NUM_PORTS'(req2_s >> start_i);
        off_s  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? mpls_port_idx_t'(i) : off_s;
        end
        sum_s   = {1'b0, start_i} + {1'b0, off_s};
        found_o = |rot_s;
        idx_o   = (sum_s >= NP_W) ? mpls_port_idx_t'(sum_s - NP_W) : mpls_port_idx_t'(sum_s);
    end

endmodule

// File: rtl/mpls_ingress_wrr_sched.sv
// Packet-granular weighted round-robin merge of NUM_PORTS AXIS streams.
// Optional per-port statistics: define MPLS_INGRESS_SCHED_STATS_EN.
module mpls_ingress_wrr_sched
    import mpls_pkg::*;
#(
    parameter int NUM_PORTS    = 8,
    parameter int DATA_BYTES   = 64,
    parameter int WEIGHT_WIDTH = 4,
    parameter int STAT_WIDTH   = 32,
    parameter int USER_WIDTH   = 3,
    parameter int ID_WIDTH     = 4,
    parameter int DEST_WIDTH   = 4
) (
    input  logic                      clk_ifc,
    input  logic                      areset_ifc,
    mpls_ingress_wrr_sched_if.slave   axis_in [NUM_PORTS],
    mpls_ingress_wrr_sched_if.master  axis_out,
    input  logic [WEIGHT_WIDTH-1:0]   port_weight [NUM_PORTS],
    output logic [STAT_WIDTH-1:0]     pkt_count   [NUM_PORTS],
    output logic [STAT_WIDTH-1:0]     beat_count  [NUM_PORTS],
    input  logic                      clear_stats
);

    localparam int DW = 8 * DATA_BYTES;
    localparam mpls_port_idx_t LAST_IDX = mpls_port_idx_t'(NUM_PORTS - 1);

    sched_state_t             state_q;
    mpls_port_idx_t           sel_q;
    logic [WEIGHT_WIDTH-1:0]  burst_q;
    logic [WEIGHT_WIDTH-1:0]  burst_d;

    logic [NUM_PORTS-1:0]     in_valid_s;
    logic [NUM_PORTS-1:0]     in_last_s;
    logic [NUM_PORTS-1:0]     sel_oh_s;
    logic [NUM_PORTS-1:0]     req_s;
    logic [NUM_PORTS-1:0]     unused_tuser_s;
    logic [DW-1:0]            in_data_s [NUM_PORTS];
    logic [DATA_BYTES-1:0]    in_keep_s [NUM_PORTS];
    logic [DATA_BYTES-1:0]    in_strb_s [NUM_PORTS];
    logic [ID_WIDTH-1:0]      in_id_s   [NUM_PORTS];
    logic [DEST_WIDTH-1:0]    in_dest_s [NUM_PORTS];

    logic                     mux_valid_s;
    logic                     mux_last_s;
    logic [DW-1:0]            mux_data_s;
    logic [DATA_BYTES-1:0]    mux_keep_s;
    logic [DATA_BYTES-1:0]    mux_strb_s;
    logic [ID_WIDTH-1:0]      mux_id_s;
    logic [DEST_WIDTH-1:0]    mux_dest_s;
    logic [WEIGHT_WIDTH-1:0]  mux_weight_s;

    logic                     xfer_s;
    logic                     out_valid_s;
    logic                     out_hs_s;
    logic                     cont_s;
    logic                     pick_found_s;
    mpls_port_idx_t           pick_idx_s;
    mpls_port_idx_t           pick_start_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign in_valid_s[g]     = axis_in[g].tvalid;
        assign in_last_s[g]      = axis_in[g].tlast;
        assign in_data_s[g]      = axis_in[g].tdata;
        assign in_keep_s[g]      = axis_in[g].tkeep;
        assign in_strb_s[g]      = axis_in[g].tstrb;
        assign in_id_s[g]        = axis_in[g].tid;
        assign in_dest_s[g]      = axis_in[g].tdest;
        assign unused_tuser_s[g] = ^axis_in[g].tuser;
        assign sel_oh_s[g]       = (sel_q == mpls_port_idx_t'(g));
        assign req_s[g]          = axis_in[g].tvalid & (port_weight[g] != '0);
        assign axis_in[g].tready = xfer_s & sel_oh_s[g] & axis_out.tready;
    end

    // One-hot AND-OR mux of the selected port's stream and weight.
    always_comb begin
        mux_valid_s  = 1'b0;
        mux_last_s   = 1'b0;
        mux_data_s   = '0;
        mux_keep_s   = '0;
        mux_strb_s   = '0;
        mux_id_s     = '0;
        mux_dest_s   = '0;
        mux_weight_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            mux_valid_s  = mux_valid_s | (sel_oh_s[i] & in_valid_s[i]);
            mux_last_s   = mux_last_s  | (sel_oh_s[i] & in_last_s[i]);
            mux_data_s   = mux_data_s  | (in_data_s[i] & {DW{sel_oh_s[i]}});
            mux_keep_s   = mux_keep_s  | (in_keep_s[i] & {DATA_BYTES{sel_oh_s[i]}});
            mux_strb_s   = mux_strb_s  | (in_strb_s[i] & {DATA_BYTES{sel_oh_s[i]}});
            mux_id_s     = mux_id_s    | (in_id_s[i]   & {ID_WIDTH{sel_oh_s[i]}});
            mux_dest_s   = mux_dest_s  | (in_dest_s[i] & {DEST_WIDTH{sel_oh_s[i]}});
            mux_weight_s = mux_weight_s | (port_weight[i] & {WEIGHT_WIDTH{sel_oh_s[i]}});
        end
    end

    assign xfer_s       = (state_q == XFER);
    assign out_valid_s  = xfer_s & mux_valid_s;
    assign out_hs_s     = out_valid_s & axis_out.tready;
    assign cont_s       = mux_valid_s & (burst_q < mux_weight_s);
    assign burst_d      = (burst_q == '1) ? burst_q : burst_q + WEIGHT_WIDTH'(1);
    assign pick_start_s = wrap_inc(sel_q, LAST_IDX);

    assign axis_out.tvalid = out_valid_s;
    assign axis_out.tdata  = mux_data_s;
    assign axis_out.tkeep  = mux_keep_s;
    assign axis_out.tstrb  = mux_strb_s;
    assign axis_out.tlast  = mux_last_s;
    assign axis_out.tid    = mux_id_s;
    assign axis_out.tdest  = mux_dest_s;
    assign axis_out.tuser  = USER_WIDTH'(sel_q);

    mpls_ingress_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i   (req_s),
        .start_i (pick_start_s),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Arbitration FSM: the same port keeps its grant while it has credit,
    // otherwise the next eligible port after sel wins with a fresh burst.
    always_ff @(posedge clk_ifc or posedge areset_ifc) begin
        if (areset_ifc) begin
            state_q <= ARB;
            sel_q   <= '0;
            burst_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (cont_s) begin
                        state_q <= XFER;
                    end else if (pick_found_s) begin
                        state_q <= XFER;
                        sel_q   <= pick_idx_s;
                        burst_q <= '0;
                    end
                end
                XFER: begin
                    if (out_hs_s && mux_last_s) begin
                        state_q <= ARB;
                        burst_q <= burst_d;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

`ifdef MPLS_INGRESS_SCHED_STATS_EN
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
        logic [STAT_WIDTH-1:0] pkt_q;
        logic [STAT_WIDTH-1:0] beat_q;
        logic                  beat_hs_s;

        assign beat_hs_s = out_hs_s & sel_oh_s[g];

        // Per-port beat/packet counters; clear has priority over a beat.
        always_ff @(posedge clk_ifc or posedge areset_ifc) begin
            if (areset_ifc) begin
                pkt_q  <= '0;
                beat_q <= '0;
            end else if (clear_stats) begin
                pkt_q  <= '0;
                beat_q <= '0;
            end else if (beat_hs_s) begin
                beat_q <= beat_q + STAT_WIDTH'(1);
                if (mux_last_s) begin
                    pkt_q <= pkt_q + STAT_WIDTH'(1);
                end
            end
        end

        assign pkt_count[g]  = pkt_q;
        assign beat_count[g] = beat_q;
    end
`else
    logic unused_clear_s;
    assign unused_clear_s = clear_stats;
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
        assign pkt_count[g]  = '0;
        assign beat_count[g] = '0;
    end
`endif

endmodule

// File: tb/tb_mpls_ingress_wrr_sched.sv
// Directed bench for mpls_ingress_wrr_sched: per-port packet sources driven
// cycle by cycle, outputs sampled on the falling edge.
module tb_mpls_ingress_wrr_sched;
    import mpls_pkg::*;

    localparam int NP = 4;
    localparam int DB = 4;
    localparam int WW = 4;
    localparam int SW = 32;
    localparam int UW = 2;

    logic clk = 1'b0;
    logic rst;
    logic o_ready;
    logic clr;
    logic [WW-1:0]     weight   [NP];
    logic [SW-1:0]     pkt_cnt  [NP];
    logic [SW-1:0]     beat_cnt [NP];
    logic              s_valid  [NP];
    logic [8*DB-1:0]   s_data   [NP];
    logic              s_last   [NP];
    logic              s_ready  [NP];
    logic              in_hs    [NP];
    logic              ready_seen [NP];
    logic              multi_rdy;

    int pk_left [NP];
    int bt      [NP];
    int plen    [NP];
    int pn      [NP];
    int gap_at  [NP];
    int gap_len [NP];
    int gap_cnt [NP];

    logic            tr[$];
    logic [UW-1:0]   q_user[$];
    logic [8*DB-1:0] q_data[$];
    logic            q_last[$];
    int              q_pkt[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpls_ingress_wrr_sched_if #(.DATA_BYTES(DB), .USER_WIDTH(UW), .ID_WIDTH(4), .DEST_WIDTH(4)) in_if [NP] ();
    mpls_ingress_wrr_sched_if #(.DATA_BYTES(DB), .USER_WIDTH(UW), .ID_WIDTH(4), .DEST_WIDTH(4)) out_if ();

    for (genvar g = 0; g < NP; g++) begin : g_src
        assign in_if[g].tvalid = s_valid[g];
        assign in_if[g].tdata  = s_data[g];
        assign in_if[g].tkeep  = '1;
        assign in_if[g].tstrb  = '1;
        assign in_if[g].tlast  = s_last[g];
        assign in_if[g].tid    = 4'(g);
        assign in_if[g].tdest  = 4'(g);
        assign in_if[g].tuser  = '1;
        assign s_ready[g]      = in_if[g].tready;
    end
    assign out_if.tready = o_ready;

    mpls_ingress_wrr_sched #(
        .NUM_PORTS(NP), .DATA_BYTES(DB), .WEIGHT_WIDTH(WW), .STAT_WIDTH(SW),
        .USER_WIDTH(UW), .ID_WIDTH(4), .DEST_WIDTH(4)
    ) dut (
        .clk_ifc     (clk),
        .areset_ifc  (rst),
        .axis_in     (in_if),
        .axis_out    (out_if),
        .port_weight (weight),
        .pkt_count   (pkt_cnt),
        .beat_count  (beat_cnt),
        .clear_stats (clr)
    );

    task automatic drive_src();
        for (int p = 0; p < NP; p++) begin
            s_valid[p] = (pk_left[p] > 0) && (gap_cnt[p] == 0);
            s_data[p]  = {8'(p), 8'(pn[p]), 16'(bt[p])};
            s_last[p]  = (bt[p] == plen[p] - 1);
        end
    endtask

    // One clock: observe at the falling edge, advance sources after the rise.
    task automatic cycle();
        int nr;
        @(negedge clk);
        tr.push_back(out_if.tvalid);
        nr = 0;
        for (int p = 0; p < NP; p++) begin
            if (s_ready[p]) begin
                ready_seen[p] = 1'b1;
                nr++;
            end
            in_hs[p] = s_valid[p] && s_ready[p];
        end
        if (nr > 1) multi_rdy = 1'b1;
        if (out_if.tvalid && o_ready) begin
            q_user.push_back(out_if.tuser);
            q_data.push_back(out_if.tdata);
            q_last.push_back(out_if.tlast);
            if (out_if.tlast) q_pkt.push_back(int'(out_if.tuser));
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (in_hs[p]) begin
                if (s_last[p]) begin
                    pk_left[p]--;
                    pn[p]++;
                    bt[p] = 0;
                end else begin
                    bt[p]++;
                end
            end
            if (gap_cnt[p] > 0) begin
                gap_cnt[p]--;
            end else if (in_hs[p] && gap_len[p] > 0 && bt[p] == gap_at[p]) begin
                gap_cnt[p] = gap_len[p];
                gap_len[p] = 0;
            end
        end
        drive_src();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clr = 1'b0;
        o_ready = 1'b1;
        multi_rdy = 1'b0;
        for (int p = 0; p < NP; p++) begin
            weight[p] = '0; pk_left[p] = 0; bt[p] = 0; plen[p] = 1; pn[p] = 0;
            gap_at[p] = 0; gap_len[p] = 0; gap_cnt[p] = 0; ready_seen[p] = 1'b0;
        end
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tr.delete(); q_user.delete(); q_data.delete(); q_last.delete(); q_pkt.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        rst = 1'b1;
        weight[0] = 4'd1; pk_left[0] = 1; plen[0] = 2;
        drive_src();
        @(negedge clk);
        total++; if (out_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", out_if.tvalid); end
        for (int p = 0; p < NP; p++) begin
            total++; if (s_ready[p] !== 1'b0) begin bad++; $display("FAIL reset_tready%0d: got %b want 0", p, s_ready[p]); end
            total++; if (pkt_cnt[p] !== '0 || beat_cnt[p] !== '0) begin bad++; $display("FAIL reset_cnt%0d: got %0d/%0d want 0/0", p, pkt_cnt[p], beat_cnt[p]); end
        end
        total++; if (dut.state_q !== ARB || dut.sel_q !== '0 || dut.burst_q !== '0) begin bad++; $display("FAIL reset_state: got st=%0d sel=%0d burst=%0d want 0/0/0", dut.state_q, dut.sel_q, dut.burst_q); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) cycle();
        total++; if (tr[0] !== 1'b0 || tr[1] !== 1'b1 || tr[2] !== 1'b1 || tr[3] !== 1'b0) begin bad++; $display("FAIL reset_first_pkt: got %b%b%b%b want 0110", tr[0], tr[1], tr[2], tr[3]); end
    endtask

    task automatic test_weights_all_one();
        int n, first, last, zeros, errs, exp_beat;
        int exp_pn [NP];
        reset_dut();
        for (int p = 0; p < NP; p++) begin
            weight[p] = 4'd1; pk_left[p] = 3; plen[p] = 4; exp_pn[p] = 0;
        end
        drive_src();
        n = 0;
        while ((pk_left[0] + pk_left[1] + pk_left[2] + pk_left[3]) != 0 && n < 300) begin
            cycle(); n++;
        end
        repeat (3) cycle();
        total++; if (n >= 300) begin bad++; $display("FAIL rr1_drain: got timeout after %0d cycles want drained", n); end
        total++; if (q_pkt.size() !== 12) begin bad++; $display("FAIL rr1_count: got %0d want 12", q_pkt.size()); end
        for (int i = 0; i < 12 && i < q_pkt.size(); i++) begin
            total++; if (q_pkt[i] !== i % 4) begin bad++; $display("FAIL rr1_order[%0d]: got %0d want %0d", i, q_pkt[i], i % 4); end
        end
        first = -1; last = -1; zeros = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i] === 1'b1) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        for (int i = first; i >= 0 && i <= last; i++) if (tr[i] !== 1'b1) zeros++;
        total++; if (first !== 1 || last - first + 1 !== 59 || zeros !== 11) begin bad++; $display("FAIL rr1_timing: got first=%0d span=%0d idle=%0d want 1/59/11", first, last - first + 1, zeros); end
        errs = 0; exp_beat = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (int'(q_data[i][31:24]) != int'(q_user[i])) errs++;
            if (int'(q_data[i][15:0]) != exp_beat) errs++;
            if (int'(q_data[i][23:16]) != exp_pn[q_user[i]]) errs++;
            if (q_last[i]) begin exp_beat = 0; exp_pn[q_user[i]]++; end
            else exp_beat++;
        end
        total++; if (errs !== 0 || q_data.size() !== 48) begin bad++; $display("FAIL rr1_stream: got errs=%0d beats=%0d want 0/48", errs, q_data.size()); end
    endtask

    task automatic test_weights_3_1();
        int errs, exp_beat;
        int exp_ord [12];
        exp_ord = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        reset_dut();
        weight[0] = 4'd3; weight[1] = 4'd1;
        pk_left[0] = 12; plen[0] = 2;
        pk_left[1] = 12; plen[1] = 2;
        drive_src();
        repeat (40) cycle();
        total++; if (q_pkt.size() < 12) begin bad++; $display("FAIL w31_count: got %0d want >=12", q_pkt.size()); end
        for (int i = 0; i < 12 && i < q_pkt.size(); i++) begin
            total++; if (q_pkt[i] !== exp_ord[i]) begin bad++; $display("FAIL w31_order[%0d]: got %0d want %0d", i, q_pkt[i], exp_ord[i]); end
        end
        errs = 0; exp_beat = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (int'(q_data[i][31:24]) != int'(q_user[i])) errs++;
            if (int'(q_data[i][15:0]) != exp_beat) errs++;
            if (i > 0 && !q_last[i-1] && q_user[i] !== q_user[i-1]) errs++;
            exp_beat = q_last[i] ? 0 : exp_beat + 1;
        end
        total++; if (errs !== 0 || multi_rdy !== 1'b0) begin bad++; $display("FAIL w31_interleave: got errs=%0d multi=%b want 0/0", errs, multi_rdy); end
    endtask

    task automatic test_disabled_port();
        int n;
        int exp_ord [6];
        exp_ord = '{0, 1, 3, 0, 1, 3};
        reset_dut();
        for (int p = 0; p < NP; p++) begin
            weight[p] = (p == 2) ? 4'd0 : 4'd1; pk_left[p] = 2; plen[p] = 3;
        end
        drive_src();
        n = 0;
        while ((pk_left[0] + pk_left[1] + pk_left[3]) != 0 && n < 200) begin
            cycle(); n++;
        end
        repeat (6) cycle();
        total++; if (n >= 200) begin bad++; $display("FAIL dis_drain: got timeout want drained"); end
        total++; if (ready_seen[2] !== 1'b0 || pk_left[2] !== 2) begin bad++; $display("FAIL dis_port2: got ready=%b left=%0d want 0/2", ready_seen[2], pk_left[2]); end
        total++; if (q_pkt.size() !== 6) begin bad++; $display("FAIL dis_count: got %0d want 6", q_pkt.size()); end
        for (int i = 0; i < 6 && i < q_pkt.size(); i++) begin
            total++; if (q_pkt[i] !== exp_ord[i]) begin bad++; $display("FAIL dis_order[%0d]: got %0d want %0d", i, q_pkt[i], exp_ord[i]); end
        end
    endtask

    task automatic test_valid_gap();
        logic [17:0] exp_tr;
        exp_tr = 18'b011000001111011011;
        reset_dut();
        for (int p = 0; p < 3; p++) weight[p] = 4'd1;
        pk_left[0] = 1; plen[0] = 6; gap_at[0] = 2; gap_len[0] = 5;
        pk_left[1] = 1; plen[1] = 2;
        pk_left[2] = 1; plen[2] = 2;
        drive_src();
        repeat (20) cycle();
        for (int c = 0; c < 18; c++) begin
            total++; if (tr[c] !== exp_tr[17-c]) begin bad++; $display("FAIL gap_tvalid[%0d]: got %b want %b", c, tr[c], exp_tr[17-c]); end
        end
        total++; if (q_pkt.size() !== 3 || q_pkt[0] !== 0 || q_pkt[1] !== 1 || q_pkt[2] !== 2) begin bad++; $display("FAIL gap_order: got n=%0d want 0,1,2", q_pkt.size()); end
    endtask

    task automatic test_reset_mid_packet();
        int exp_b;
`ifdef MPLS_INGRESS_SCHED_STATS_EN
        exp_b = 2;
`else
        exp_b = 0;
`endif
        reset_dut();
        weight[1] = 4'd1; pk_left[1] = 1; plen[1] = 8;
        drive_src();
        repeat (3) cycle();
        total++; if (out_if.tvalid !== 1'b1 || out_if.tuser !== 2'd1) begin bad++; $display("FAIL rstmid_pre: got v=%b user=%0d want 1/1", out_if.tvalid, out_if.tuser); end
        total++; if (beat_cnt[1] !== SW'(exp_b)) begin bad++; $display("FAIL rstmid_beats: got %0d want %0d", beat_cnt[1], exp_b); end
        rst = 1'b1;
        #1;
        total++; if (out_if.tvalid !== 1'b0 || s_ready[1] !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got v=%b rdy=%b want 0/0", out_if.tvalid, s_ready[1]); end
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (dut.sel_q !== '0 || dut.state_q !== ARB) begin bad++; $display("FAIL rstmid_sel: got sel=%0d st=%0d want 0/0", dut.sel_q, dut.state_q); end
        total++; if (beat_cnt[1] !== '0 || pkt_cnt[1] !== '0) begin bad++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", beat_cnt[1], pkt_cnt[1]); end
    endtask

    task automatic test_stats();
        int n, ep, eb, e2, e1;
`ifdef MPLS_INGRESS_SCHED_STATS_EN
        ep = 10; eb = 60; e2 = 2; e1 = 1;
`else
        ep = 0; eb = 0; e2 = 0; e1 = 0;
`endif
        reset_dut();
        weight[1] = 4'd1; pk_left[1] = 10; plen[1] = 6;
        drive_src();
        n = 0;
        while (pk_left[1] != 0 && n < 400) begin
            cycle(); n++;
        end
        total++; if (n >= 400) begin bad++; $display("FAIL stats_drain: got timeout want drained"); end
        total++; if (pkt_cnt[1] !== SW'(ep) || beat_cnt[1] !== SW'(eb)) begin bad++; $display("FAIL stats_count: got %0d/%0d want %0d/%0d", pkt_cnt[1], beat_cnt[1], ep, eb); end
        total++; if (pkt_cnt[0] !== '0 || beat_cnt[0] !== '0) begin bad++; $display("FAIL stats_other: got %0d/%0d want 0/0", pkt_cnt[0], beat_cnt[0]); end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        total++; if (pkt_cnt[1] !== '0 || beat_cnt[1] !== '0) begin bad++; $display("FAIL stats_clear: got %0d/%0d want 0/0", pkt_cnt[1], beat_cnt[1]); end
        pk_left[1] = 1;
        drive_src();
        repeat (3) cycle();
        total++; if (beat_cnt[1] !== SW'(e2)) begin bad++; $display("FAIL stats_partial: got %0d want %0d", beat_cnt[1], e2); end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        total++; if (beat_cnt[1] !== '0) begin bad++; $display("FAIL stats_clear_wins: got %0d want 0", beat_cnt[1]); end
        cycle();
        total++; if (beat_cnt[1] !== SW'(e1)) begin bad++; $display("FAIL stats_after_clear: got %0d want %0d", beat_cnt[1], e1); end
    endtask

    initial begin
        test_reset();
        test_weights_all_one();
        test_weights_3_1();
        test_disabled_port();
        test_valid_gap();
        test_reset_mid_packet();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpls_ingress_wrr_sched.md
# mpls_ingress_wrr_sched

Packet-granular weighted round-robin scheduler that merges NUM_PORTS same-width ingress AXIS streams onto the single converged ingress bus feeding the MPLS core. It is the successor to plain round-robin arbitration: per-port weights, per-port enable and an optional statistics block. Packets are never interleaved, and the winning port index is carried in tuser. It sits in the core clock domain, after the per-port width-adaptation and CDC FIFOs.

## Interface
- NUM_PORTS, 8: number of ingress streams, 1..32.
- DATA_BYTES, 64: tdata width in bytes, inputs and output.
- WEIGHT_WIDTH, 4: width of each per-port weight (packets per grant).
- STAT_WIDTH, 32: width of each statistics counter.
- clk_ifc  input  1  core clock (Clock_int).
- areset_ifc  input  1  reset, asynchronous assert, active-high (Reset_int).
- axis_in[NUM_PORTS]  AXIS slave  DATA_BYTES  ingress streams; tuser ignored.
- axis_out  AXIS master  DATA_BYTES  converged bus.
  - USER_WIDTH ≥ clog2(NUM_PORTS); tuser = source port index, zero-extended.
- port_weight[NUM_PORTS]  input  WEIGHT_WIDTH each  maximum consecutive packets per grant.
  - 0 disables the port.
- pkt_count[NUM_PORTS]  output  STAT_WIDTH each  packets forwarded per port.
- beat_count[NUM_PORTS]  output  STAT_WIDTH each  beats forwarded per port.
- clear_stats  input  1  synchronous clear of all counters.

## Operation
- State machine with two states.
  - ARB: evaluates candidates; no beats are transferred.
  - XFER: selected port connected to axis_out; tvalid/tready/tdata/tkeep/tstrb/tlast/tid/tdest pass combinationally; tuser = sel.
- ARB decision, in order:
  - Continue: if axis_in[sel].tvalid=1 and burst_cnt < port_weight[sel], re-grant sel and keep burst_cnt.
  - New grant: otherwise search ports sel+1, sel+2 … wrapping to sel for the first one with tvalid=1 and port_weight≠0. Set sel to it and burst_cnt=0.
  - No candidate: stay in ARB.
- XFER → ARB on the tlast handshake (tvalid & tready & tlast); burst_cnt increments on the same edge.
- Unselected inputs see tready=0. axis_out.tvalid=0 in ARB.
- Weight is compared at each ARB cycle. A weight change mid-packet never aborts the packet. A weight lowered below burst_cnt ends the burst at the next ARB.
- Source tvalid drop mid-packet: remain in XFER; output tvalid follows the source (bubbles allowed).
- burst_cnt saturates at 2^WEIGHT_WIDTH-1; sel wraps NUM_PORTS-1 → 0.
- All weights 0: scheduler stays in ARB indefinitely, with no output.

## Timing
- Reset state: ARB, sel=0, burst_cnt=0, all inputs tready=0, axis_out.tvalid=0, counters 0.
- Reset asserted mid-packet: output deasserts immediately and the packet is truncated downstream. This is accepted: the upstream FIFOs are reset together with this block.
- Arbitration latency is one ARB cycle per packet, the first beat appearing the cycle after ARB. Peak efficiency is L/(L+1) for L-beat packets.
- Data path latency is zero cycles; there are no internal registers on tdata.
- Counters update on the cycle after the handshake. A beat handshake and clear_stats in the same cycle: clear wins.
- Counters wrap modulo 2^STAT_WIDTH.

## Configuration
- MPLS_INGRESS_SCHED_STATS_EN defined: pkt_count and beat_count are implemented as above.
- Undefined: the counters are not instantiated; pkt_count and beat_count are tied to 0 and clear_stats is ignored. The port list is identical in both builds.

## Structure
- mpls_pkg holds:
  - typedef mpls_port_idx_t (logic [clog2(MAX_PORTS)-1:0]);
  - localparam MAX_PORTS=32;
  - enum sched_state_t {ARB, XFER}.
- Sub-module mpls_ingress_rr_pick: combinational rotating priority finder.
  - Inputs: request vector and start index.
  - Outputs: found flag and index.
  - Reused by the egress scheduler.

## Test plan
- Weights all 1, ports 0–3 each with three 4-beat packets queued -> output order 0,1,2,3 repeated; one idle cycle between packets; tuser matches the source.
- Weights {3,1}, both ports saturated -> repeating pattern P0,P0,P0,P1; no beat interleaving across tlast.
- port_weight[2]=0 with port 2 tvalid held high -> port 2 never granted and its tready stays 0; all other ports drain.
- Source deasserts tvalid for 5 cycles mid-packet while other ports are valid -> no grant change until tlast; output tvalid gaps match the source.
- areset_ifc pulsed during beat 3 of an 8-beat packet -> axis_out.tvalid=0 that cycle; after release, sel=0 and counters=0.
- STATS_EN build: 10 packets of 6 beats on port 1 -> pkt_count[1]=10, beat_count[1]=60; clear_stats -> 0. Non-STATS build: both stay 0.
